// File: rtl/avalonsemi_nibble_bridge.sv
// Nibble-serial register bridge: a 4-bit header/data stream writes, increments,
// clears and reads back a bank of WORD_W-bit channel registers.
module avalonsemi_nibble_bridge #(
  parameter int WORD_W   = 16,
  parameter int CHANNELS = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [3:0]                   nib_in,
  input  logic                         nib_valid,
  output logic [CHANNELS*WORD_W-1:0]   ch_q,
  output logic [CHANNELS-1:0]          wr_strobe,
  output logic [3:0]                   nib_out,
  output logic                         nib_out_valid,
  output logic                         busy,
  output logic                         ovr
);

  localparam int N  = WORD_W / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_INC   = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [1:0]            chan_reg, chan_next;
  logic [WORD_W-1:0]     asm_reg, asm_next;
  logic [WORD_W-1:0]     shift_reg, shift_next;
  logic [3:0]            nib_out_reg, nib_out_next;
  logic                  nib_out_valid_reg, nib_out_valid_next;
  logic [CHANNELS-1:0]   wr_strobe_reg, wr_strobe_next;
  logic                  ovr_reg, ovr_next;

  logic                  do_write, do_inc, do_clear;
  logic [1:0]            sel_chan;
  logic [CHANNELS-1:0]   sel_oh;
  logic [CHANNELS*WORD_W-1:0] masked_flat;
  logic [WORD_W-1:0]     snap;

  // The header nibble carries the channel in IDLE; afterwards the latched one applies.
  assign sel_chan = (state_reg == IDLE) ? nib_in[1:0] : chan_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WORD_W-1:0] word_reg;

      assign sel_oh[gi] = (sel_chan == 2'(gi));
      assign masked_flat[gi*WORD_W +: WORD_W] = sel_oh[gi] ? word_reg : '0;
      assign ch_q[gi*WORD_W +: WORD_W] = word_reg;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          word_reg <= '0;
        end else if (do_clear) begin
          word_reg <= '0;
        end else if (do_write && sel_oh[gi]) begin
          word_reg <= asm_next;
        end else if (do_inc && sel_oh[gi]) begin
          word_reg <= word_reg + WORD_W'(1);
        end
      end
    end
  endgenerate

  // Out-of-range channels select nothing, so the snapshot reads as zero.
  always_comb begin
    snap = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      snap = snap | masked_flat[c*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    chan_next          = chan_reg;
    asm_next           = asm_reg;
    shift_next         = shift_reg;
    nib_out_next       = 4'h0;
    nib_out_valid_next = 1'b0;
    wr_strobe_next     = '0;
    ovr_next           = ovr_reg;
    do_write           = 1'b0;
    do_inc             = 1'b0;
    do_clear           = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (nib_valid) begin
          chan_next = nib_in[1:0];
          cnt_next  = '0;
          case (nib_in[3:2])
            CMD_WRITE: begin
              asm_next   = '0;
              state_next = WDATA;
            end
            CMD_READ: begin
              state_next         = RDATA;
              nib_out_valid_next = 1'b1;
              nib_out_next       = snap[3:0];
              shift_next         = snap >> 4;
            end
            CMD_INC: begin
              do_inc         = 1'b1;
              wr_strobe_next = sel_oh;
            end
            default: begin // CLEAR
              do_clear       = 1'b1;
              ovr_next       = 1'b0;
              wr_strobe_next = '1;
            end
          endcase
        end
      end

      WDATA: begin
        if (nib_valid) begin
          asm_next[{cnt_reg, 2'b00} +: 4] = nib_in;
          if (cnt_reg == LAST) begin
            do_write       = 1'b1;
            wr_strobe_next = sel_oh;
            state_next     = IDLE;
            cnt_next       = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      RDATA: begin
        if (nib_valid) begin
          ovr_next = 1'b1;
        end
        if (cnt_reg == LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next           = cnt_reg + 1'b1;
          nib_out_valid_next = 1'b1;
          nib_out_next       = shift_reg[3:0];
          shift_next         = shift_reg >> 4;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      chan_reg          <= '0;
      asm_reg           <= '0;
      shift_reg         <= '0;
      nib_out_reg       <= 4'h0;
      nib_out_valid_reg <= 1'b0;
      wr_strobe_reg     <= '0;
      ovr_reg           <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      chan_reg          <= chan_next;
      asm_reg           <= asm_next;
      shift_reg         <= shift_next;
      nib_out_reg       <= nib_out_next;
      nib_out_valid_reg <= nib_out_valid_next;
      wr_strobe_reg     <= wr_strobe_next;
      ovr_reg           <= ovr_next;
    end
  end

  assign nib_out       = nib_out_reg;
  assign nib_out_valid = nib_out_valid_reg;
  assign wr_strobe     = wr_strobe_reg;
  assign ovr           = ovr_reg;
  assign busy          = (state_reg == RDATA);

endmodule
